// File: rtl/uart_packet_decoder_pkg.sv
// Shared constants and state encoding for the UART packet decoder.
// Holds the SYNC byte, CMD codes and err_code values so decoder and benches agree.
// No logic; import with uart_packet_decoder_pkg::*.
package uart_packet_decoder_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] CMD_WRITE    = 8'h01;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_FORMAT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/uart_pkt_buffer.sv
// Payload store: DEPTH x 8 register file, one synchronous write port, one async read port.
// Latency: write lands on the clock edge, read is combinational from the stored word.
// Backpressure: none; the caller controls the write enable.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
module uart_pkt_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // Contents are deliberately not reset; nothing reads them until a packet refills them.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_packet_decoder.sv
// Decodes A5/CMD/ADDR/LEN/payload/CHK packets from a UART byte stream into register writes.
// Latency: first wr_valid the cycle after CHK is accepted; pkt_ok/pkt_err are registered pulses.
// Backpressure: wr_valid holds addr/data until wr_ready; rx bytes arriving during COMMIT are dropped (overrun).
// Ports: clk, reset_n (sync, active-low); rx_data/rx_valid byte input; wr_valid/wr_ready/wr_addr/wr_data
//        write channel; pkt_ok, pkt_err, err_code, busy, overrun status.
import uart_packet_decoder_pkg::*;

module uart_packet_decoder #(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 48_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic       overrun
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state_q, state_d;
    logic [7:0]      addr_q, len_q, chk_q;
    logic [IW-1:0]   idx_q;
    logic [TW-1:0]   tmo_q;
    logic            pkt_ok_q, pkt_err_q, overrun_q;
    logic [1:0]      err_code_q;

    logic            timed_state, timeout_fire, byte_acc, idx_last;
    logic            err_set, ok_set;
    logic [1:0]      err_code_d;
    logic [7:0]      rd_dat;

    assign timed_state  = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                          (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign timeout_fire = timed_state && (tmo_q == TW'(TIMEOUT_CYCLES));
    // A byte coinciding with the timeout is discarded: the packet is already dead.
    assign byte_acc     = rx_valid && !timeout_fire;
    assign idx_last     = (8'(idx_q) == (len_q - 8'd1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_set    = 1'b0;
        err_code_d = err_code_q;
        ok_set     = 1'b0;
        unique case (state_q)
            ST_HUNT: begin
                if (byte_acc && rx_data == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_acc) begin
                    if (rx_data != CMD_WRITE) begin
                        state_d    = ST_HUNT;
                        err_set    = 1'b1;
                        err_code_d = ERR_FORMAT;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_acc) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byte_acc) begin
                    if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) begin
                        state_d    = ST_HUNT;
                        err_set    = 1'b1;
                        err_code_d = ERR_FORMAT;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_acc && idx_last) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (byte_acc) begin
                    if (rx_data != chk_q) begin
                        state_d    = ST_HUNT;
                        err_set    = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (wr_ready && idx_last) begin
                    state_d = ST_HUNT;
                    ok_set  = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase
        if (timeout_fire) begin
            state_d    = ST_HUNT;
            err_set    = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q     <= 8'h00;
            len_q      <= 8'h00;
            chk_q      <= 8'h00;
            idx_q      <= '0;
            tmo_q      <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            overrun_q  <= 1'b0;
        end else begin
            pkt_ok_q  <= ok_set;
            pkt_err_q <= err_set;
            if (err_set) err_code_q <= err_code_d;
            if (state_q == ST_COMMIT && rx_valid) overrun_q <= 1'b1;

            if (byte_acc || !timed_state) tmo_q <= '0;
            else                          tmo_q <= tmo_q + 1'b1;

            if (byte_acc) begin
                unique case (state_q)
                    ST_HUNT:    chk_q <= 8'h00;
                    ST_CMD:     chk_q <= chk_q ^ rx_data;
                    ST_ADDR: begin
                        chk_q  <= chk_q ^ rx_data;
                        addr_q <= rx_data;
                    end
                    ST_LEN: begin
                        chk_q <= chk_q ^ rx_data;
                        len_q <= rx_data;
                        idx_q <= '0;
                    end
                    ST_PAYLOAD: begin
                        chk_q <= chk_q ^ rx_data;
                        // Wrap back to 0 so COMMIT replays from the first byte.
                        idx_q <= idx_last ? '0 : idx_q + 1'b1;
                    end
                    default: ;
                endcase
            end

            if (state_q == ST_COMMIT && wr_ready) idx_q <= idx_q + 1'b1;
        end
    end

    uart_pkt_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_buf (
        .clk   (clk),
        .we    (state_q == ST_PAYLOAD && byte_acc),
        .waddr (idx_q),
        .wdata (rx_data),
        .raddr (idx_q),
        .rdata (rd_dat)
    );

    // Address/data are gated so idle outputs read zero and never expose stale buffer contents.
    assign wr_valid = (state_q == ST_COMMIT);
    assign wr_addr  = wr_valid ? addr_q + 8'(idx_q) : 8'h00;
    assign wr_data  = wr_valid ? rd_dat : 8'h00;
    assign pkt_ok   = pkt_ok_q;
    assign pkt_err  = pkt_err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != ST_HUNT);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
module tb_uart_packet_decoder;
    import uart_packet_decoder_pkg::*;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_packet_decoder #(
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pkt_ok   (pkt_ok),
        .pkt_err  (pkt_err),
        .err_code (err_code),
        .busy     (busy),
        .overrun  (overrun)
    );

    // Presents one byte for exactly one cycle; returns on the falling edge right after it was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({wr_valid, wr_addr, wr_data} !== {1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_wr got %b/%h/%h exp 0/00/00", wr_valid, wr_addr, wr_data);
        end
        vectors++;
        if ({pkt_ok, pkt_err, err_code} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_pkt got ok=%b err=%b code=%b exp 0 0 00", pkt_ok, pkt_err, err_code);
        end
        vectors++;
        if ({busy, overrun} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_status got busy=%b overrun=%b exp 0 0", busy, overrun);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hunt_noise();
        logic [7:0] noise [3];
        noise = '{8'h00, 8'h5A, 8'h01};
        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i]);
            vectors++;
            if ({busy, pkt_err} !== 2'b00) begin
                miscompares++;
                $display("FAIL hunt_noise%0d got busy=%b err=%b exp 0 0", i, busy, pkt_err);
            end
        end
    endtask

    // A5 01 10 02 11 22, checksum 01^10^02^11^22 = 20.
    task automatic test_basic_write(input string tag);
        logic [7:0] p [7];
        p = '{8'hA5, 8'h01, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
        wr_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_byte(p[i]);
        vectors++;
        if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h10, 8'h11}) begin
            miscompares++;
            $display("FAIL %s_w0 got %b/%h/%h exp 1/10/11", tag, wr_valid, wr_addr, wr_data);
        end
        @(negedge clk);
        vectors++;
        if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h11, 8'h22}) begin
            miscompares++;
            $display("FAIL %s_w1 got %b/%h/%h exp 1/11/22", tag, wr_valid, wr_addr, wr_data);
        end
        @(negedge clk);
        vectors++;
        if ({wr_valid, pkt_ok, pkt_err} !== 3'b010) begin
            miscompares++;
            $display("FAIL %s_done got wr_valid=%b ok=%b err=%b exp 0 1 0", tag, wr_valid, pkt_ok, pkt_err);
        end
        @(negedge clk);
        vectors++;
        if ({pkt_ok, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_idle got ok=%b busy=%b exp 0 0", tag, pkt_ok, busy);
        end
    endtask

    task automatic test_chk_err();
        logic [7:0] p [7];
        int         seen;
        p = '{8'hA5, 8'h01, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        for (int i = 0; i < 7; i++) send_byte(p[i]);
        vectors++;
        if ({pkt_err, err_code, wr_valid} !== {1'b1, ERR_CHECKSUM, 1'b0}) begin
            miscompares++;
            $display("FAIL chk_err got err=%b code=%b wr_valid=%b exp 1 01 0", pkt_err, err_code, wr_valid);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_valid || pkt_ok) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL chk_err_nowrite got %0d write/ok cycles exp 0", seen);
        end
    endtask

    task automatic test_bad_header();
        send_byte(8'hA5);
        send_byte(8'h02);
        vectors++;
        if ({pkt_err, err_code, busy} !== {1'b1, ERR_FORMAT, 1'b0}) begin
            miscompares++;
            $display("FAIL bad_cmd got err=%b code=%b busy=%b exp 1 10 0", pkt_err, err_code, busy);
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        vectors++;
        if ({pkt_err, err_code} !== {1'b1, ERR_FORMAT}) begin
            miscompares++;
            $display("FAIL len_zero got err=%b code=%b exp 1 10", pkt_err, err_code);
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        vectors++;
        if ({pkt_err, err_code, busy} !== {1'b1, ERR_FORMAT, 1'b0}) begin
            miscompares++;
            $display("FAIL len_17 got err=%b code=%b busy=%b exp 1 10 0", pkt_err, err_code, busy);
        end
    endtask

    // A5 01 FF 02 AA BB, checksum 01^FF^02^AA^BB = ED; address wraps FF -> 00.
    task automatic test_stall_wrap();
        logic [7:0] p [7];
        p = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hED};
        wr_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(p[i]);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'hFF, 8'hAA}) begin
                miscompares++;
                $display("FAIL stall%0d got %b/%h/%h exp 1/FF/AA", k, wr_valid, wr_addr, wr_data);
            end
            if (k == 3) wr_ready = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h00, 8'hBB}) begin
            miscompares++;
            $display("FAIL wrap got %b/%h/%h exp 1/00/BB", wr_valid, wr_addr, wr_data);
        end
        @(negedge clk);
        vectors++;
        if ({wr_valid, pkt_ok} !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_done got wr_valid=%b ok=%b exp 0 1", wr_valid, pkt_ok);
        end
    endtask

    task automatic test_timeout();
        int n;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        // Error flag lands TMO idle cycles plus one register stage after the last byte.
        n = 0;
        while (!pkt_err && n < TMO + 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== TMO + 1) begin
            miscompares++;
            $display("FAIL timeout_delay got %0d cycles exp %0d", n, TMO + 1);
        end
        vectors++;
        if ({pkt_err, err_code, busy} !== {1'b1, ERR_TIMEOUT, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_flags got err=%b code=%b busy=%b exp 1 11 0", pkt_err, err_code, busy);
        end
        test_basic_write("after_tmo");

        // LEN equal to the maximum is legal; abandon it mid-payload to hit the timeout there.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        vectors++;
        if ({pkt_err, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL len_max got err=%b busy=%b exp 0 1", pkt_err, busy);
        end
        send_byte(8'h33);
        n = 0;
        while (!pkt_err && n < TMO + 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ({n == TMO + 1, err_code} !== {1'b1, ERR_TIMEOUT}) begin
            miscompares++;
            $display("FAIL payload_tmo got %0d cycles code=%b exp %0d 11", n, err_code, TMO + 1);
        end
    endtask

    // A5 01 20 04 01 02 03 04, checksum 01^20^04^01^02^03^04 = 21.
    task automatic test_reset_commit();
        logic [7:0] p [9];
        int         seen;
        p = '{8'hA5, 8'h01, 8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h21};
        wr_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(p[i]);
        vectors++;
        if ({wr_valid, wr_addr, wr_data, overrun} !== {1'b1, 8'h20, 8'h01, 1'b0}) begin
            miscompares++;
            $display("FAIL commit4 got %b/%h/%h ovr=%b exp 1/20/01 0", wr_valid, wr_addr, wr_data, overrun);
        end
        send_byte(8'h55);
        vectors++;
        if ({wr_valid, wr_addr, wr_data, overrun} !== {1'b1, 8'h20, 8'h01, 1'b1}) begin
            miscompares++;
            $display("FAIL overrun got %b/%h/%h ovr=%b exp 1/20/01 1", wr_valid, wr_addr, wr_data, overrun);
        end
        wr_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wr_addr, wr_data, overrun} !== {8'h21, 8'h02, 1'b1}) begin
            miscompares++;
            $display("FAIL overrun_sticky got %h/%h ovr=%b exp 21/02 1", wr_addr, wr_data, overrun);
        end
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({wr_valid, wr_addr, wr_data, pkt_ok, pkt_err, err_code, busy, overrun} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_mid_commit got wv=%b a=%h d=%h ok=%b err=%b code=%b busy=%b ovr=%b exp all 0",
                     wr_valid, wr_addr, wr_data, pkt_ok, pkt_err, err_code, busy, overrun);
        end
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wr_valid || pkt_ok || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL post_reset_quiet got %0d active cycles exp 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_hunt_noise();
        test_basic_write("basic");
        test_chk_err();
        test_bad_header();
        test_stall_wrap();
        test_timeout();
        test_reset_commit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
